// File: rtl/ifq_pkg.sv
// Shared types for the multi-lane instruction queue.
package ifq_pkg;

   localparam int IFQ_DEPTH  = 16;
   localparam int IFQ_DATA_W = 32;
   localparam int IFQ_ADDR_W = 32;

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      WAIT_SLOT = 2'd1,
      HOLD      = 2'd2
   } ifq_state_e;

   // One queue entry: instruction word plus its PC.
   typedef struct packed {
      logic [IFQ_DATA_W-1:0] data;
      logic [IFQ_ADDR_W-1:0] addr;
   } ifq_entry_t;

   typedef logic [$clog2(IFQ_DEPTH)-1:0]   ifq_ptr_t;
   typedef logic [$clog2(IFQ_DEPTH+1)-1:0] ifq_cnt_t;

endpackage

// File: rtl/ifq_prefix_count.sv
// Length of the contiguous run of ones starting at bit 0 of a lane-enable vector.
module ifq_prefix_count #(
   parameter int N = 2
) (
   input  logic [N-1:0]               vec_i,
   output logic [$clog2(N+1)-1:0]     len_o
);

   logic run;

   // Count ones until the first zero; later ones do not contribute.
   always_comb begin
      len_o = '0;
      run   = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (run && vec_i[i]) begin
            len_o = len_o + 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/instruction_queue.sv
// Multi-lane circular instruction/PC queue between fetch and decode, with
// branch delay-slot tracking and a flush mode that preserves one delay slot.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  NORMAL    | queue entries drive the read lanes
//  WAIT_SLOT | flush kept a slot that has not been fetched yet; lanes idle
//  HOLD      | held delay slot presented on lane 0; queue refills behind it
//
// Entry storage uses ifq_entry_t, so DATA_W/ADDR_W must match the package widths.
module instruction_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH    = IFQ_DEPTH,
   parameter int WR_LANES = 2,
   parameter int RD_LANES = 2,
   parameter int DATA_W   = IFQ_DATA_W,
   parameter int ADDR_W   = IFQ_ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         flush_keep,
   input  logic [WR_LANES-1:0]          wr_en,
   input  logic [WR_LANES*DATA_W-1:0]   wr_data,
   input  logic [WR_LANES*ADDR_W-1:0]   wr_addr,
   input  logic [RD_LANES-1:0]          rd_en,
   input  logic [RD_LANES-1:0]          rd_branch,
   output logic [RD_LANES-1:0]          out_valid,
   output logic [RD_LANES*DATA_W-1:0]   out_data,
   output logic [RD_LANES*ADDR_W-1:0]   out_addr,
   output logic [RD_LANES-1:0]          out_delay_slot,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int WL_W  = $clog2(WR_LANES+1);
   localparam int RL_W  = $clog2(RD_LANES+1);

   ifq_entry_t        mem_q [DEPTH];
   ifq_entry_t        held_q, held_d;
   ifq_entry_t        wr_entry [WR_LANES];
   ifq_entry_t        rd_entry;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   ifq_state_e        state_q, state_d;
   logic              ds_pending_q, ds_pending_d;
   logic              overflow_q, overflow_d;
   logic              full_w;
   logic              lane_valid;

   logic [WL_W-1:0]   n_wr;
   logic [RL_W-1:0]   n_rd;
   int                nwr_i;
   int                n_pop;
   int                hold_lane;
   // Queue write window: lanes qw_first..qw_first+qw_cnt-1 land at qw_base onward.
   logic [PTR_W-1:0]  qw_base;
   int                qw_first;
   int                qw_cnt;

   ifq_prefix_count #(.N(WR_LANES)) u_wr_prefix (.vec_i(wr_en), .len_o(n_wr));
   ifq_prefix_count #(.N(RD_LANES)) u_rd_prefix (.vec_i(rd_en), .len_o(n_rd));

   assign full_w       = (DEPTH - int'(count_q)) < WR_LANES;
   assign full         = full_w;
   assign empty        = (count_q == '0);
   assign count        = count_q;
   assign overflow_err = overflow_q;

   // Unpack the flat write buses into per-lane entries.
   always_comb begin
      for (int j = 0; j < WR_LANES; j++) begin
         wr_entry[j].data = wr_data[j*DATA_W +: DATA_W];
         wr_entry[j].addr = wr_addr[j*ADDR_W +: ADDR_W];
      end
   end

   // Next-state: flush handling, FSM, pop/push accounting and delay-slot tracking.
   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      state_d      = state_q;
      ds_pending_d = ds_pending_q;
      overflow_d   = overflow_q;
      held_d       = held_q;
      nwr_i        = int'(n_wr);
      n_pop        = 0;
      hold_lane    = 0;
      qw_base      = wr_ptr_q;
      qw_first     = 0;
      qw_cnt       = 0;

      if (flush) begin
         state_d      = NORMAL;
         ds_pending_d = 1'b0;
         qw_base      = '0;
         if (state_q == NORMAL && flush_keep) begin
            if (count_q >= CNT_W'(2)) begin
               held_d  = mem_q[rd_ptr_q + PTR_W'(1)];
               state_d = HOLD;
            end else if (wr_en[0] && (count_q == CNT_W'(1) || nwr_i >= 2)) begin
               // The slot follows the stored head (count 1) or the incoming head (count 0).
               hold_lane = (count_q == CNT_W'(1)) ? 0 : 1;
               for (int j = 0; j < WR_LANES; j++) begin
                  if (j == hold_lane) held_d = wr_entry[j];
               end
               qw_first = hold_lane + 1;
               qw_cnt   = nwr_i - hold_lane - 1;
               state_d  = HOLD;
            end else begin
               state_d = WAIT_SLOT;
            end
         end
         rd_ptr_d = '0;
         wr_ptr_d = PTR_W'(qw_cnt);
         count_d  = CNT_W'(qw_cnt);
      end else begin
         case (state_q)
            NORMAL: begin
               n_pop = int'(n_rd);
               if (n_pop > int'(count_q)) n_pop = int'(count_q);
               for (int i = 0; i < RD_LANES; i++) begin
                  if (n_pop == i + 1) ds_pending_d = rd_branch[i];
               end
            end
            WAIT_SLOT: begin
               if (wr_en[0]) begin
                  held_d   = wr_entry[0];
                  qw_first = 1;
                  qw_cnt   = nwr_i - 1;
                  state_d  = HOLD;
               end
            end
            HOLD: begin
               if (rd_en[0]) begin
                  ds_pending_d = rd_branch[0];
                  state_d      = NORMAL;
               end
            end
            default: state_d = NORMAL;
         endcase

         if (state_q != WAIT_SLOT && nwr_i != 0) begin
            if (full_w) begin
               overflow_d = 1'b1;
            end else begin
               qw_cnt = nwr_i;
            end
         end

         rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(qw_cnt);
         count_d  = CNT_W'(int'(count_q) + qw_cnt - n_pop);
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= NORMAL;
         ds_pending_q <= 1'b0;
         overflow_q   <= 1'b0;
         held_q       <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         ds_pending_q <= ds_pending_d;
         overflow_q   <= overflow_d;
         held_q       <= held_d;
      end
   end

   // Entry storage, one write port per lane, deliberately not reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int j = 0; j < WR_LANES; j++) begin
            if (j >= qw_first && j < qw_first + qw_cnt) begin
               mem_q[qw_base + PTR_W'(j - qw_first)] <= wr_entry[j];
            end
         end
      end
   end

   // Read lanes: queue head window in NORMAL, held slot on lane 0 in HOLD.
   always_comb begin
      out_valid      = '0;
      out_data       = '0;
      out_addr       = '0;
      out_delay_slot = '0;
      rd_entry       = '0;
      lane_valid     = 1'b0;
      for (int i = 0; i < RD_LANES; i++) begin
         rd_entry   = '0;
         lane_valid = 1'b0;
         if (state_q == NORMAL && i < int'(count_q)) begin
            lane_valid = 1'b1;
            rd_entry   = mem_q[rd_ptr_q + PTR_W'(i)];
         end else if (state_q == HOLD && i == 0) begin
            lane_valid = 1'b1;
            rd_entry   = held_q;
         end
         out_valid[i]                   = lane_valid;
         out_data[i*DATA_W +: DATA_W]   = rd_entry.data;
         out_addr[i*ADDR_W +: ADDR_W]   = rd_entry.addr;
      end
      out_delay_slot[0] = out_valid[0] & ((state_q == HOLD) | ds_pending_q);
   end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: a vector table for steady-state
// push/pop/wrap behaviour plus hand-written flush and delay-slot sequences.
module tb_instruction_queue;

   localparam logic [31:0] K = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, flush_keep;
   logic [1:0]  wr_en;
   logic [63:0] wr_data, wr_addr;
   logic [1:0]  rd_en, rd_branch;
   logic [1:0]  out_valid;
   logic [63:0] out_data, out_addr;
   logic [1:0]  out_delay_slot;
   logic [4:0]  count;
   logic        empty, full, overflow_err;

   int n_total = 0;
   int n_pass  = 0;

   instruction_queue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .flush_keep(flush_keep),
      .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr),
      .rd_en(rd_en), .rd_branch(rd_branch),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
      .out_delay_slot(out_delay_slot), .count(count), .empty(empty),
      .full(full), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl, kp;
      logic [1:0]  wen;
      logic [31:0] a0, a1;
      logic [1:0]  ren, br;
      int          cnt;
      logic [1:0]  val;
      logic [31:0] e0, e1;
      logic        ds, fu, ov;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic fl, logic kp, logic [1:0] wen, logic [31:0] a0, logic [31:0] a1,
                               logic [1:0] ren, logic [1:0] br, int cnt, logic [1:0] val,
                               logic [31:0] e0, logic [31:0] e1, logic ds, logic fu, logic ov);
      vec_t v;
      v.fl = fl; v.kp = kp; v.wen = wen; v.a0 = a0; v.a1 = a1; v.ren = ren; v.br = br;
      v.cnt = cnt; v.val = val; v.e0 = e0; v.e1 = e1; v.ds = ds; v.fu = fu; v.ov = ov;
      return v;
   endfunction

   // PC sequence seen by the fill/wrap section: 16 fill entries then pairs from 0x2000.
   function automatic logic [31:0] seq_pc(int i);
      if (i < 16) return 32'h1000 + 32'(4 * i);
      return 32'h2000 + 32'(4 * (i - 16));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic step(input logic fl, input logic kp, input logic [1:0] wen,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] ren, input logic [1:0] br);
      flush      = fl;
      flush_keep = kp;
      wr_en      = wen;
      wr_addr    = {a1, a0};
      wr_data    = {a1 ^ K, a0 ^ K};
      rd_en      = ren;
      rd_branch  = br;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string nm, input int cnt, input logic [1:0] val,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic ds, input logic fu, input logic ov);
      logic [31:0] ea0, ea1, ed0, ed1;
      ea0 = val[0] ? e0 : 32'h0;
      ea1 = val[1] ? e1 : 32'h0;
      ed0 = val[0] ? (e0 ^ K) : 32'h0;
      ed1 = val[1] ? (e1 ^ K) : 32'h0;
      chk({nm, ".count"},  32'(count), 32'(cnt));
      chk({nm, ".valid"},  32'(out_valid), 32'(val));
      chk({nm, ".addr0"},  out_addr[31:0], ea0);
      chk({nm, ".addr1"},  out_addr[63:32], ea1);
      chk({nm, ".data0"},  out_data[31:0], ed0);
      chk({nm, ".data1"},  out_data[63:32], ed1);
      chk({nm, ".dslot"},  32'(out_delay_slot), {31'b0, ds});
      chk({nm, ".full"},   32'(full), {31'b0, fu});
      chk({nm, ".empty"},  32'(empty), {31'b0, (cnt == 0)});
      chk({nm, ".ovf"},    32'(overflow_err), {31'b0, ov});
   endtask

   initial begin
      // ---------------- vector table ----------------
      // Mixed push/pop and delay-slot tracking from a reset queue.
      tbl.push_back(mk(0,0,2'b11,32'h100,32'h104,2'b00,2'b00, 2,2'b11,32'h100,32'h104,0,0,0));
      tbl.push_back(mk(0,0,2'b01,32'h108,32'h0,  2'b00,2'b00, 3,2'b11,32'h100,32'h104,0,0,0));
      tbl.push_back(mk(0,0,2'b11,32'h10C,32'h110,2'b01,2'b01, 4,2'b11,32'h104,32'h108,1,0,0));
      tbl.push_back(mk(0,0,2'b10,32'hDEAD,32'hBEEF,2'b00,2'b00,4,2'b11,32'h104,32'h108,1,0,0));
      tbl.push_back(mk(0,0,2'b00,32'h0,  32'h0,  2'b11,2'b00, 2,2'b11,32'h10C,32'h110,0,0,0));
      tbl.push_back(mk(0,0,2'b00,32'h0,  32'h0,  2'b11,2'b10, 0,2'b00,32'h0,  32'h0,  0,0,0));
      tbl.push_back(mk(0,0,2'b01,32'h114,32'h0,  2'b00,2'b00, 1,2'b01,32'h114,32'h0,  1,0,0));
      tbl.push_back(mk(0,0,2'b00,32'h0,  32'h0,  2'b11,2'b00, 0,2'b00,32'h0,  32'h0,  0,0,0));
      tbl.push_back(mk(0,0,2'b00,32'h0,  32'h0,  2'b01,2'b00, 0,2'b00,32'h0,  32'h0,  0,0,0));
      // Fill to full, two per cycle.
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(0,0,2'b11,seq_pc(2*k),seq_pc(2*k+1),2'b00,2'b00,
                          2*(k+1),2'b11,seq_pc(0),seq_pc(1),0,(k == 7),0));
      // Write while full is dropped and flags overflow.
      tbl.push_back(mk(0,0,2'b11,32'hBAD0,32'hBAD4,2'b00,2'b00,16,2'b11,seq_pc(0),seq_pc(1),0,1,1));
      tbl.push_back(mk(0,0,2'b00,32'h0,  32'h0,  2'b11,2'b00,14,2'b11,seq_pc(2),seq_pc(3),0,0,1));
      // Steady pop-2/push-2 across the pointer wrap.
      for (int m = 0; m < 10; m++)
         tbl.push_back(mk(0,0,2'b11,seq_pc(16+2*m),seq_pc(17+2*m),2'b11,2'b00,
                          14,2'b11,seq_pc(4+2*m),seq_pc(5+2*m),0,0,1));
      // Plain flush discards contents and same-cycle writes.
      tbl.push_back(mk(1,0,2'b11,32'h7770,32'h7774,2'b11,2'b00,0,2'b00,32'h0,32'h0,0,0,1));

      // ---------------- reset ----------------
      rst_n = 1'b0;
      step(0,0,2'b00,32'h0,32'h0,2'b00,2'b00);
      step(0,0,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("reset", 0, 2'b00, 32'h0, 32'h0, 0, 0, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].fl, tbl[i].kp, tbl[i].wen, tbl[i].a0, tbl[i].a1, tbl[i].ren, tbl[i].br);
         expect_st($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].val, tbl[i].e0, tbl[i].e1,
                   tbl[i].ds, tbl[i].fu, tbl[i].ov);
      end

      // ---------------- flush_keep with count >= 2 ----------------
      step(0,0,2'b11,32'h200,32'h204,2'b00,2'b00);
      step(0,0,2'b01,32'h208,32'h0,  2'b00,2'b00);
      expect_st("keep.fill", 3, 2'b11, 32'h200, 32'h204, 0, 0, 1);
      step(1,1,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("keep.hold", 0, 2'b01, 32'h204, 32'h0, 1, 0, 1);
      step(0,0,2'b00,32'h0,32'h0,2'b01,2'b00);
      expect_st("keep.pop", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);
      step(0,0,2'b01,32'h20C,32'h0,2'b00,2'b00);
      expect_st("keep.normal", 1, 2'b01, 32'h20C, 32'h0, 0, 0, 1);
      step(0,0,2'b00,32'h0,32'h0,2'b01,2'b00);
      expect_st("keep.drain", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);

      // ---------------- WAIT_SLOT path ----------------
      step(0,0,2'b01,32'h300,32'h0,2'b00,2'b00);
      expect_st("wait.pre", 1, 2'b01, 32'h300, 32'h0, 0, 0, 1);
      step(1,1,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("wait.enter", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);
      step(0,0,2'b10,32'h3F0,32'h3F4,2'b01,2'b00);
      expect_st("wait.stay", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);
      step(0,0,2'b11,32'h304,32'h400,2'b00,2'b00);
      expect_st("wait.hold", 1, 2'b01, 32'h304, 32'h0, 1, 0, 1);
      step(0,0,2'b01,32'h404,32'h0,2'b00,2'b00);
      expect_st("hold.write", 2, 2'b01, 32'h304, 32'h0, 1, 0, 1);
      step(0,0,2'b00,32'h0,32'h0,2'b01,2'b00);
      expect_st("hold.pop", 2, 2'b11, 32'h400, 32'h404, 0, 0, 1);
      step(1,0,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("wait.flush", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);

      // ---------------- flush_keep, empty queue, slot from write lane 1 ----------------
      step(1,1,2'b11,32'h500,32'h504,2'b00,2'b00);
      expect_st("keep0.hold", 0, 2'b01, 32'h504, 32'h0, 1, 0, 1);
      step(1,1,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("hold.flush", 0, 2'b00, 32'h0, 32'h0, 0, 0, 1);

      // ---------------- flush_keep, one entry, slot from write lane 0 ----------------
      step(0,0,2'b01,32'h600,32'h0,2'b00,2'b00);
      step(1,1,2'b11,32'h604,32'h608,2'b00,2'b00);
      expect_st("keep1.hold", 1, 2'b01, 32'h604, 32'h0, 1, 0, 1);
      step(0,0,2'b00,32'h0,32'h0,2'b01,2'b00);
      expect_st("keep1.pop", 1, 2'b01, 32'h608, 32'h0, 0, 0, 1);

      // ---------------- reset clears sticky overflow ----------------
      rst_n = 1'b0;
      step(0,0,2'b00,32'h0,32'h0,2'b00,2'b00);
      expect_st("rereset", 0, 2'b00, 32'h0, 32'h0, 0, 0, 0);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
